// File: rtl/seq_detect_param_if.sv
// Bus between the pattern-detector and the logic that feeds it bits and
// reads its match status.
interface seq_detect_param_if #(
    parameter int LEN   = 8,
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_valid;
    logic             overlap;
    logic             pat_load;
    logic [LEN-1:0]   pat_in;
    logic [LEN-1:0]   mask_in;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output din, din_valid, overlap, pat_load, pat_in, mask_in, cnt_clr,
        input  match, match_count, armed
    );

    modport slave (
        input  din, din_valid, overlap, pat_load, pat_in, mask_in, cnt_clr,
        output match, match_count, armed
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern and
// don't-care mask, overlap/flush match modes and a saturating match counter.
module seq_detect_param #(
    parameter int             LEN         = 8,
    parameter logic [LEN-1:0] RST_PATTERN = LEN'(8'b01000101),
    parameter logic [LEN-1:0] RST_MASK    = '1,
    parameter int             CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_param_if.slave  bus
);
    localparam int             FW        = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0]  FILL_LAST = FW'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    // Only the LEN-1 newest bits are stored: the oldest bit of the window is
    // consumed by the compare and is never needed again.
    state_t           r_state;
    logic [LEN-2:0]   r_hist;
    logic [FW-1:0]    r_fill;
    logic [LEN-1:0]   r_pat;
    logic [LEN-1:0]   r_mask;
    logic             r_match;
    logic [CNT_W-1:0] r_count;

    state_t           w_state_next;
    logic [LEN-2:0]   w_hist_next;
    logic [FW-1:0]    w_fill_next;
    logic [LEN-1:0]   w_pat_next;
    logic [LEN-1:0]   w_mask_next;
    logic             w_match_next;
    logic [CNT_W-1:0] w_count_next;

    logic             w_accept;
    logic [LEN-1:0]   w_nh;
    logic [LEN-1:0]   w_miss;
    logic [FW-1:0]    w_fill_inc;
    logic             w_hit;

    assign w_accept   = bus.din_valid & ~bus.pat_load;
    assign w_nh       = {r_hist, bus.din};
    assign w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;

    generate
        for (genvar gi = 0; gi < LEN; gi++) begin : g_cmp
            assign w_miss[gi] = (w_nh[gi] ^ r_pat[gi]) & r_mask[gi];
        end
    endgenerate

    assign w_hit = w_accept && (r_fill >= FILL_LAST) && (w_miss == '0);

    always_comb begin
        w_state_next = r_state;
        w_hist_next  = r_hist;
        w_fill_next  = r_fill;
        w_pat_next   = r_pat;
        w_mask_next  = r_mask;
        w_match_next = 1'b0;
        w_count_next = r_count;

        if (bus.pat_load) begin
            w_pat_next   = bus.pat_in;
            w_mask_next  = bus.mask_in;
            w_hist_next  = '0;
            w_fill_next  = '0;
            w_state_next = S_FILL;
        end else if (bus.din_valid) begin
            w_match_next = w_hit;
            // armed reflects the window that was just completed, even when a
            // flush empties the history on this same edge.
            w_state_next = (w_fill_inc == FILL_FULL) ? S_ARMED : S_FILL;
            if (w_hit && !bus.overlap) begin
                w_hist_next = '0;
                w_fill_next = '0;
            end else begin
                w_hist_next = w_nh[LEN-2:0];
                w_fill_next = w_fill_inc;
            end
        end else begin
            w_state_next = (r_fill == FILL_FULL) ? S_ARMED : S_FILL;
        end

        if (bus.cnt_clr) begin
            w_count_next = '0;
        end else if (w_hit && (r_count != CNT_MAX)) begin
            w_count_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= RST_PATTERN;
            r_mask  <= RST_MASK;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_hist  <= w_hist_next;
            r_fill  <= w_fill_next;
            r_pat   <= w_pat_next;
            r_mask  <= w_mask_next;
            r_match <= w_match_next;
            r_count <= w_count_next;
        end
    end

    assign bus.match       = r_match;
    assign bus.match_count = r_count;
    assign bus.armed       = (r_state == S_ARMED);
endmodule
